// File: rtl/vga_pkg.sv
// Shared widths, frame default and FSM state type for the VGA plot arbiter.
package vga_pkg;

  localparam int unsigned X_W                  = 8;
  localparam int unsigned Y_W                  = 7;
  localparam int unsigned COL_W                = 3;
  localparam int unsigned DEFAULT_FRAME_CYCLES = 833333;

  typedef enum logic {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } state_e;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int unsigned      k;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(ptr_i) + i;
      if (k >= N_REQ) begin
        k = k - N_REQ;
      end
      idx = IDX_W'(k);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        idx_o        = idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA write port between N_REQ requesters,
// with an optional burst limit and a free-running frame tick.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned MAX_BURST    = 256,
  parameter int unsigned FRAME_CYCLES = DEFAULT_FRAME_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       plot_in,
  input  logic [X_W*N_REQ-1:0]   x_in,
  input  logic [Y_W*N_REQ-1:0]   y_in,
  input  logic [COL_W*N_REQ-1:0] colour_in,
  output logic [N_REQ-1:0]       grant,
  output logic [X_W-1:0]         x_out,
  output logic [Y_W-1:0]         y_out,
  output logic [COL_W-1:0]       colour_out,
  output logic                   plot_out,
  output logic                   frame_tick,
  output logic                   busy
);

  localparam int unsigned IDX_W   = cnt_w(N_REQ);
  localparam int unsigned BURST_W = cnt_w(MAX_BURST);
  localparam int unsigned FRAME_W = cnt_w(FRAME_CYCLES);

  localparam logic [BURST_W-1:0] BURST_LAST =
      (MAX_BURST == 0) ? {BURST_W{1'b1}} : BURST_W'(MAX_BURST - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COL_W-1:0]   col_q, col_d;

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  logic             own_req, own_plot, others_req, timeout;
  logic [X_W-1:0]   own_x;
  logic [Y_W-1:0]   own_y;
  logic [COL_W-1:0] own_col;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Owner lanes are selected by the one-hot grant register.
  always_comb begin
    own_x   = '0;
    own_y   = '0;
    own_col = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        own_x   = x_in[i*X_W +: X_W];
        own_y   = y_in[i*Y_W +: Y_W];
        own_col = colour_in[i*COL_W +: COL_W];
      end
    end
  end

  assign own_req    = |(req & grant_q);
  assign own_plot   = |(plot_in & grant_q);
  assign others_req = |(req & ~grant_q);
  assign timeout    = (MAX_BURST != 0) && (burst_q == BURST_LAST) && others_req;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    frame_d  = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StOwn;
          grant_d = pick_grant;
          owner_d = pick_idx;
          burst_d = '0;
        end
      end
      StOwn: begin
        // Release and timeout collapse into one release; that cycle's write is dropped.
        if (!own_req || timeout) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
        end else begin
          plot_d = own_plot;
          x_d    = own_x;
          y_d    = own_y;
          col_d  = own_col;
          if (burst_q != BURST_LAST) begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      frame_q  <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      frame_q  <= frame_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign plot_out   = plot_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;
  assign frame_tick = (frame_q == FRAME_LAST);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: a burst-limited instance (A) and an
// unlimited instance (B) share stimulus; each scenario checks one of them.
module tb_vga_plot_arbiter;

  typedef struct packed {
    logic [2:0] grant;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } exp_t;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic [2:0]  req       = '0;
  logic [2:0]  plot_in   = '0;
  logic [23:0] x_in      = {8'd42, 8'd21, 8'd10};
  logic [20:0] y_in      = {7'd52, 7'd31, 7'd20};
  logic [8:0]  colour_in = {3'd7, 3'd2, 3'd4};

  logic [2:0] grant_a, grant_b, col_a, col_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic       plot_a, plot_b, tick_a, tick_b, busy_a, busy_b;

  logic [7:0] lx [3] = '{8'd10, 8'd21, 8'd42};
  logic [6:0] ly [3] = '{7'd20, 7'd31, 7'd52};
  logic [2:0] lc [3] = '{3'd4, 3'd2, 3'd7};

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned fcnt     = 0;
  exp_t        sb_q[$];
  logic        sel_b    = 1'b0;
  logic [7:0]  ex       = '0;
  logic [6:0]  ey       = '0;
  logic [2:0]  ec       = '0;

  vga_plot_arbiter #(
    .N_REQ        (3),
    .MAX_BURST    (4),
    .FRAME_CYCLES (10)
  ) u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .plot_in    (plot_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .grant      (grant_a),
    .x_out      (x_a),
    .y_out      (y_a),
    .colour_out (col_a),
    .plot_out   (plot_a),
    .frame_tick (tick_a),
    .busy       (busy_a)
  );

  vga_plot_arbiter #(
    .N_REQ        (3),
    .MAX_BURST    (0),
    .FRAME_CYCLES (10)
  ) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .plot_in    (plot_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .grant      (grant_b),
    .x_out      (x_b),
    .y_out      (y_b),
    .colour_out (col_b),
    .plot_out   (plot_b),
    .frame_tick (tick_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
    end
  endtask

  // Expected frame position; the tick must fire when it sits at 9.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) fcnt <= 0;
    else          fcnt <= (fcnt == 9) ? 0 : fcnt + 1;
  end

  always @(negedge clk) begin
    check("tick_a", 32'(tick_a), 32'(fcnt == 9));
    check("tick_b", 32'(tick_b), 32'(fcnt == 9));
  end

  task automatic check_cleared(input string tag);
    check({tag, "_grant_a"}, 32'(grant_a), 0);
    check({tag, "_plot_a"},  32'(plot_a),  0);
    check({tag, "_xyc_a"},   32'({x_a, y_a, col_a}), 0);
    check({tag, "_busy_a"},  32'(busy_a),  0);
    check({tag, "_grant_b"}, 32'(grant_b), 0);
    check({tag, "_plot_b"},  32'(plot_b),  0);
    check({tag, "_xyc_b"},   32'({x_b, y_b, col_b}), 0);
    check({tag, "_busy_b"},  32'(busy_b),  0);
  endtask

  // Called 1 time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    ex = '0;
    ey = '0;
    ec = '0;
    #1 check_cleared(tag);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  // Push the outputs expected after the next edge, then pop and compare there.
  task automatic step(input string tag, input logic [2:0] g, input logic p, input int lane);
    exp_t       e;
    logic [2:0] g_o, c_o;
    logic [7:0] x_o;
    logic [6:0] y_o;
    logic       p_o, b_o;
    if (lane >= 0) begin
      ex = lx[lane];
      ey = ly[lane];
      ec = lc[lane];
    end
    sb_q.push_back('{grant: g, plot: p, x: ex, y: ey, col: ec});
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    g_o = sel_b ? grant_b : grant_a;
    p_o = sel_b ? plot_b  : plot_a;
    x_o = sel_b ? x_b     : x_a;
    y_o = sel_b ? y_b     : y_a;
    c_o = sel_b ? col_b   : col_a;
    b_o = sel_b ? busy_b  : busy_a;
    check({tag, "_grant"}, 32'(g_o), 32'(e.grant));
    check({tag, "_plot"},  32'(p_o), 32'(e.plot));
    check({tag, "_x"},     32'(x_o), 32'(e.x));
    check({tag, "_y"},     32'(y_o), 32'(e.y));
    check({tag, "_col"},   32'(c_o), 32'(e.col));
    check({tag, "_busy"},  32'(b_o), 32'(|e.grant));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    do_reset("rst0");

    // Single requester: grant after 1 edge, pixel out after the next.
    sel_b   = 1'b0;
    req     = 3'b001;
    plot_in = 3'b001;
    step("s1_arb", 3'b001, 1'b0, -1);
    step("s1_own", 3'b001, 1'b1, 0);
    step("s1_own", 3'b001, 1'b1, 0);
    req = 3'b000;
    step("s1_rel", 3'b000, 1'b0, -1);
    step("s1_idl", 3'b000, 1'b0, -1);

    // Round robin on the unlimited instance, each owner holding 5 cycles.
    sel_b = 1'b1;
    do_reset("rst1");
    req     = 3'b111;
    plot_in = 3'b111;
    for (int k = 0; k < 3; k++) begin
      step("s2_arb", 3'(1 << k), 1'b0, -1);
      for (int j = 0; j < 5; j++) begin
        plot_in = (j == 2) ? 3'b000 : 3'b111;
        step("s2_own", 3'(1 << k), (j != 2), k);
      end
      req[k]  = 1'b0;
      plot_in = 3'b111;
      step("s2_rel", 3'b000, 1'b0, -1);
    end
    step("s2_idl", 3'b000, 1'b0, -1);

    // Burst limit 4 with a competing requester.
    sel_b = 1'b0;
    do_reset("rst2");
    req     = 3'b011;
    plot_in = 3'b001;
    step("s3_arb", 3'b001, 1'b0, -1);
    repeat (3) step("s3_own", 3'b001, 1'b1, 0);
    step("s3_tmo", 3'b000, 1'b0, -1);
    step("s3_arb1", 3'b010, 1'b0, -1);
    step("s3_own1", 3'b010, 1'b0, 1);

    // No competitor: counter saturates and owner keeps grant.
    do_reset("rst3");
    req     = 3'b001;
    plot_in = 3'b001;
    step("s4_arb", 3'b001, 1'b0, -1);
    repeat (10) step("s4_hold", 3'b001, 1'b1, 0);
    req = 3'b011;
    step("s4_tmo", 3'b000, 1'b0, -1);
    step("s4_arb1", 3'b010, 1'b0, -1);

    // Reset mid-burst with rr_ptr moved off zero.
    do_reset("rst4");
    req     = 3'b001;
    plot_in = 3'b001;
    step("s5_arb0", 3'b001, 1'b0, -1);
    req = 3'b000;
    step("s5_rel0", 3'b000, 1'b0, -1);
    req     = 3'b010;
    plot_in = 3'b010;
    step("s5_arb1", 3'b010, 1'b0, -1);
    step("s5_own1", 3'b010, 1'b1, 1);
    do_reset("s5_async");
    req     = 3'b111;
    plot_in = 3'b000;
    step("s5_first", 3'b001, 1'b0, -1);
    step("s5_own", 3'b001, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the single VGA write port.
REQ-002 Parameter MAX_BURST, default 256: maximum grant cycles while another requester waits; 0 disables the limit.
REQ-003 Parameter FRAME_CYCLES, default 833333: clk cycles per frame tick (60 Hz at 50 MHz).
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  system clock (CLOCK_50 domain).
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 req  in  N_REQ  per-requester request; held high for the whole burst.
REQ-008 plot_in  in  N_REQ  per-requester pixel-write strobe.
REQ-009 x_in  in  8*N_REQ  packed x coordinates; requester i occupies bits [8i+7:8i].
REQ-010 y_in  in  7*N_REQ  packed y coordinates; requester i occupies bits [7i+6:7i].
REQ-011 colour_in  in  3*N_REQ  packed colours; requester i occupies bits [3i+2:3i].
REQ-012 grant  out  N_REQ  one-hot or zero ownership indication.
REQ-013 x_out  out  8, y_out  out  7, colour_out  out  3, plot_out  out  1: signals to the vga_adapter.
REQ-014 frame_tick  out  1  single-cycle pulse, once per frame.
REQ-015 busy  out  1  high while any grant is held.

Function
REQ-016 The FSM SHALL have two states: IDLE (no owner) and OWN (one owner).
REQ-017 In IDLE with any req high, the arbiter SHALL select the first set req at or above rr_ptr, wrapping modulo N_REQ; grant SHALL rise on the next edge and the state SHALL become OWN.
REQ-018 In OWN, outputs SHALL be registered from the owner's lanes: plot_out = plot_in[owner], with x, y and colour copied alongside; latency SHALL be 1 cycle.
REQ-019 In OWN, plot_in, x, y and colour from non-owners SHALL be ignored; in IDLE, plot_out SHALL be 0 and x, y and colour SHALL hold their last values.
REQ-020 When the owner samples with req low, the arbiter SHALL drop grant next cycle, set rr_ptr = (owner+1) mod N_REQ and enter IDLE; the owner's plot_in in that cycle SHALL be discarded.
REQ-021 A burst counter SHALL count OWN cycles starting at 0 on entry.
REQ-022 If MAX_BURST≠0, the counter reaches MAX_BURST-1 and another req is high, the arbiter SHALL force a release identical to REQ-020.
REQ-023 If no other req is high, the counter SHALL saturate and the owner SHALL keep the grant.
REQ-024 A simultaneous owner release and timeout SHALL be treated as a single release.
REQ-025 IDLE SHALL last at least one cycle between owners, so grants never overlap and plot_out is 0 in the handover cycle.
REQ-026 The frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; frame_tick SHALL be high exactly in the wrap cycle, independent of arbitration.
REQ-027 Counter widths SHALL be $clog2 of their limits; no arithmetic SHALL truncate at the default parameter values.
REQ-028 busy SHALL equal |grant.

Reset
REQ-029 While reset_n is low, the state SHALL be IDLE; grant, plot_out, x_out, y_out, colour_out, frame_tick and busy SHALL be 0; rr_ptr, the burst counter and the frame counter SHALL be 0.
REQ-030 A reset asserted mid-burst SHALL clear the grant immediately (asynchronously), with no write emitted after reset_n falls.
REQ-031 After reset_n rises, the first arbitration SHALL favour requester 0.

Structure
REQ-032 A shared package vga_pkg SHALL hold X_W=8, Y_W=7, COL_W=3, the default FRAME_CYCLES and the state enum.
REQ-033 One sub-module, rr_pick, SHALL be used: combinational round-robin select (req vector and rr_ptr in; one-hot grant and index out).

Verification
REQ-034 After reset, with req=001, plot_in=001 and x0=10, y0=20, colour0=3'b100: grant=001 after 1 cycle; plot_out=1 with x_out=10, y_out=20, colour_out=4 on the following cycle.
REQ-035 With req=111 from IDLE and rr_ptr=0: grants follow 001, 010, 100, each separated by one IDLE cycle with plot_out=0, as each owner drops req after 5 cycles.
REQ-036 With MAX_BURST=4, owner 0 holding and req[1] high: forced release after 4 OWN cycles, then grant=010 two cycles later; the same setup with req[1] low holds grant=001 indefinitely.
REQ-037 With FRAME_CYCLES=10: frame_tick pulses on cycles 9, 19 and 29 after reset, unaffected by concurrent arbitration.
REQ-038 Asserting reset_n low mid-burst while plot_in=1: grant and plot_out go 0 without a clock edge; after release, the first grant goes to requester 0.
